// File: rtl/cla_add_sequencer.sv
// Byte-serial add/subtract sequencer built around one 8-bit carry-lookahead slice.
// Optional CLA_ADD_SEQ_PIPE_EN lets a new operation start on the retire edge.
module cla_add_sequencer #(
  parameter int NUM_BYTES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_a,
  input  logic [8*NUM_BYTES-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;

  logic [7:0]      w_sliceA;
  logic [7:0]      w_sliceB;
  logic [7:0]      w_sliceSum;
  logic [7:0]      w_g;
  logic [7:0]      w_p;
  logic [3:0]      w_cLo;
  logic [3:0]      w_cHi;
  logic [3:0]      w_gLo;
  logic            w_c4;
  logic            w_sliceCout;
  logic            w_sliceOvf;
  logic            w_accept;

  // Returns the four carries c4..c1 of a nibble, each as a flat lookahead term.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic cin);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  assign w_sliceA = r_a[8*r_idx +: 8];
  assign w_sliceB = r_b[8*r_idx +: 8];
  assign w_g      = w_sliceA & w_sliceB;
  assign w_p      = w_sliceA ^ w_sliceB;

  // Upper nibble carry-in comes from the lower nibble's group generate/propagate.
  assign w_gLo       = cla4(w_g[3:0], w_p[3:0], 1'b0);
  assign w_c4        = w_gLo[3] | ((&w_p[3:0]) & r_carry);
  assign w_cLo       = cla4(w_g[3:0], w_p[3:0], r_carry);
  assign w_cHi       = cla4(w_g[7:4], w_p[7:4], w_c4);
  assign w_sliceSum  = w_p ^ {w_cHi[2:0], w_c4, w_cLo[2:0], r_carry};
  assign w_sliceCout = w_cHi[3];
  assign w_sliceOvf  = (r_a[W-1] == r_b[W-1]) && (w_sliceSum[7] != r_a[W-1]);

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (r_idx == LAST) w_next = DONE;
      end
      DONE: begin
`ifdef CLA_ADD_SEQ_PIPE_EN
        in_ready = out_ready;
        if (out_ready) w_next = in_valid ? RUN : IDLE;
`else
        if (out_ready) w_next = IDLE;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_sub ? ~in_b : in_b;
        r_carry <= in_sub;
        r_idx   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (r_state == RUN) begin
        r_sum[8*r_idx +: 8] <= w_sliceSum;
        r_carry             <= w_sliceCout;
        // The index parks on the last byte so it can never wrap inside RUN.
        if (r_idx == LAST) begin
          r_cout <= w_sliceCout;
          r_ovf  <= w_sliceOvf;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule

// File: doc/cla_add_sequencer.md
Name: cla_add_sequencer

Overview:
Multi-cycle adder/subtractor controller. It time-shares one internal 8-bit carry-lookahead slice to add or subtract NUM_BYTES-byte operands, processing one byte per clock from LSB to MSB. The slice carry-out is registered between beats. It sits beside the ALU as the low-area add path, with valid/ready handshakes on both the operand side and the result side.

Parameters:
NUM_BYTES, 4, operand width in bytes (W = 8*NUM_BYTES); legal values 2..8.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_sub  input  1  1 = compute A-B, 0 = compute A+B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  result
out_cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
out_ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, byte index=0, carry register=0. Reset wins over every other event, including mid-RUN and DONE with out_ready high. An in-flight operation is discarded and no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch: a_reg=in_a; b_reg=in_sub ? ~in_b : in_b; carry=in_sub; idx=0; clear out_sum.
  - Go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the slice computes a_reg[8*idx+:8] + b_reg[8*idx+:8] + carry.
  - Write the sum byte into out_sum[8*idx+:8]; carry <= slice carry-out; idx <= idx+1.
  - When idx==NUM_BYTES-1: set out_cout = slice carry-out and out_ovf = (a_msb == b_reg_msb) && (sum_msb != a_msb), then go to DONE.
- DONE:
  - out_valid=1.
  - out_sum, out_cout and out_ovf are held stable while out_ready=0.
  - On out_ready=1, go to IDLE with out_valid=0 the next cycle.
- Latency: the op is accepted on edge T; out_valid is first high in the cycle after edge T+NUM_BYTES (NUM_BYTES RUN cycles).
- Throughput without the optional feature: one op every NUM_BYTES+2 cycles minimum.
- Input handling:
  - in_a, in_b and in_sub are sampled only at the accept edge.
  - Changes during RUN or DONE have no effect.
  - in_valid asserted outside IDLE is ignored, and it is not queued.
- out_sum bytes not yet written during RUN read 0. Only the DONE value is architecturally meaningful.
- Arithmetic: modulo 2^W, with no saturation.
  - Subtract uses A + ~B + 1.
  - out_cout=1 on sub means A >= B (unsigned).
- idx width: clog2(NUM_BYTES). idx never wraps past NUM_BYTES-1 inside RUN; it resets to 0 on accept.

Optional Feature:
Macro CLA_ADD_SEQ_PIPE_EN.
- Defined:
  - in_ready = IDLE || (DONE && out_ready).
  - In DONE, if out_ready=1 and in_valid=1 on the same edge, the result is retired and the new operands are latched. The FSM goes directly DONE -> RUN.
  - out_valid=0 in the following cycle.
  - Back-to-back throughput is one op per NUM_BYTES+1 cycles.
- Undefined:
  - in_ready = IDLE only.
  - DONE always returns to IDLE first.

Test Plan:
- Byte carry chain: add 0x000000FF + 0x00000001 -> out_sum=0x00000100, cout=0, ovf=0; out_valid first high exactly 4 cycles after the accept edge.
- Full ripple: add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0. Then add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Subtract: 5 - 7 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then 0x80000000 - 1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE, toggling in_a/in_b/in_valid throughout -> result unchanged, in_ready=0, nothing accepted; result retired on the first out_ready=1.
- Reset mid-operation: assert reset at RUN idx=2 for one cycle -> next cycle IDLE, out_valid=0, out_sum=0, in_ready=1; a subsequent 0x12345678 + 0x11111111 yields 0x23456789.
- With CLA_ADD_SEQ_PIPE_EN: keep in_valid=1 and out_ready=1 across two ops -> second accept coincides with the first retire edge; the results arrive 5 cycles apart.
